// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared TinyALU opcode encoding.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op     = 3'b000,
    add_op    = 3'b001,
    and_op    = 3'b010,
    xor_op    = 3'b011,
    mul_op    = 3'b100,
    fun_op    = 3'b101,
    unused_op = 3'b110,
    rst_op    = 3'b111
  } operation_t;

endpackage

// File: rtl/tinyalu_core.sv
// tinyalu_core: responder side of the TinyALU start/done protocol.
// add/and/xor complete one edge after acceptance; mul/fun complete after
// MUL_LAT/FUN_LAT edges using a down-counter with terminal-count compare.
// Optional macro TINYALU_ERR_EN adds the err output and makes opcode 110
// a one-cycle erroring op instead of a silent no_op.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// BUSY  | executing latched op; counter runs down to zero
// REARM | op finished; wait for start to drop before re-arming
module tinyalu_core
  import tinyalu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3,
  parameter int FUN_LAT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               done,
  output logic               busy,
  output logic [2*WIDTH-1:0] result
`ifdef TINYALU_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int RW = 2 * WIDTH;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] FUN_CNT = 4'(FUN_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    REARM = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  operation_t       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [RW-1:0]    result_q, result_d;
  logic             err_q, err_d;

  logic [RW-1:0] a_ext, b_ext;
  logic [RW-1:0] add_res, and_res, xor_res, mul_res, fun_res;
  operation_t    op_in;

  assign op_in   = operation_t'(op);
  assign a_ext   = RW'(a_q);
  assign b_ext   = RW'(b_q);
  assign add_res = a_ext + b_ext;
  assign and_res = a_ext & b_ext;
  assign xor_res = a_ext ^ b_ext;
  assign mul_res = a_ext * b_ext;
  assign fun_res = (a_ext * a_ext) + b_ext;

  // State, latched operands and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      op_q     <= no_op;
      a_q      <= '0;
      b_q      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Next-state, counter and output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_in;
          a_d     = A;
          b_d     = B;
          state_d = BUSY;
          // Single-cycle and non-computing ops pass through BUSY with a
          // zero count so every op resolves on the edge after acceptance.
          case (op_in)
            mul_op: begin
              cnt_d  = MUL_CNT;
              busy_d = 1'b1;
            end
            fun_op: begin
              cnt_d  = FUN_CNT;
              busy_d = 1'b1;
            end
            default: begin
              cnt_d  = 4'd0;
              busy_d = 1'b0;
            end
          endcase
        end
      end

      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = REARM;
          busy_d  = 1'b0;
          case (op_q)
            add_op: begin
              result_d = add_res;
              done_d   = 1'b1;
              err_d    = 1'b0;
            end
            and_op: begin
              result_d = and_res;
              done_d   = 1'b1;
              err_d    = 1'b0;
            end
            xor_op: begin
              result_d = xor_res;
              done_d   = 1'b1;
              err_d    = 1'b0;
            end
            mul_op: begin
              result_d = mul_res;
              done_d   = 1'b1;
              err_d    = 1'b0;
            end
            fun_op: begin
              result_d = fun_res;
              done_d   = 1'b1;
              err_d    = 1'b0;
            end
            rst_op: begin
              result_d = '0;
            end
`ifdef TINYALU_ERR_EN
            unused_op: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
`endif
            default: begin
            end
          endcase
        end
      end

      REARM: begin
        if (!start) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign done   = done_q;
  assign busy   = busy_q;
  assign result = result_q;

`ifdef TINYALU_ERR_EN
  assign err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_tinyalu_core.sv
// tb_tinyalu_core: directed vectors with hand-computed expectations.
module tb_tinyalu_core;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        done;
  logic        busy;
  logic [15:0] result;
`ifdef TINYALU_ERR_EN
  logic        err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int ndone;

  tinyalu_core #(
    .WIDTH  (8),
    .MUL_LAT(3),
    .FUN_LAT(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .done  (done),
    .busy  (busy),
    .result(result)
`ifdef TINYALU_ERR_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op and let the acceptance edge pass; start stays high.
  task automatic start_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    op    = o;
    A     = a;
    B     = b;
    start = 1'b1;
    tick();
  endtask

  // Drop start long enough for REARM to return to IDLE.
  task automatic end_op();
    start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    start = 1'b0;
    op    = 3'b000;
    A     = 8'h00;
    B     = 8'h00;
    reset = 1'b1;
    tick();
    tick();
    check("rst_done",   32'(done),   32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_result", 32'(result), 32'h0);
    reset = 1'b0;
    tick();

    // add with carry into bit 8
    start_op(3'b001, 8'hFF, 8'h01);
    check("add_acc_done", 32'(done), 32'd0);
    check("add_acc_busy", 32'(busy), 32'd0);
    tick();
    check("add_done",   32'(done),   32'd1);
    check("add_result", 32'(result), 32'h0100);
    check("add_busy",   32'(busy),   32'd0);
    tick();
    check("add_done_once", 32'(done), 32'd0);
    end_op();

    // mul, MUL_LAT=3, start held past done
    start_op(3'b100, 8'hFF, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      check("mul_busy",   32'(busy), 32'd1);
      check("mul_nodone", 32'(done), 32'd0);
      tick();
    end
    check("mul_done",   32'(done),   32'd1);
    check("mul_result", 32'(result), 32'hFE01);
    check("mul_busy_end", 32'(busy), 32'd0);
    ndone = 0;
    repeat (4) begin
      tick();
      ndone += int'(done);
    end
    check("mul_held_nodone", 32'(ndone), 32'd0);
    end_op();

    // fun, FUN_LAT=4; operands and start change during BUSY
    start_op(3'b101, 8'h10, 8'h05);
    A     = 8'h00;
    B     = 8'h00;
    start = 1'b0;
    repeat (3) tick();
    check("fun_early", 32'(done), 32'd0);
    tick();
    check("fun_done",   32'(done),   32'd1);
    check("fun_result", 32'(result), 32'h0105);
    tick();
    tick();

    // reset mid-mul
    start_op(3'b100, 8'h07, 8'h09);
    tick();
    reset = 1'b1;
    start = 1'b0;
    tick();
    check("rmid_done",   32'(done),   32'd0);
    check("rmid_busy",   32'(busy),   32'd0);
    check("rmid_result", 32'(result), 32'h0);
    reset = 1'b0;
    ndone = 0;
    repeat (5) begin
      tick();
      ndone += int'(done);
    end
    check("rmid_nodone", 32'(ndone), 32'd0);
    start_op(3'b001, 8'h02, 8'h03);
    tick();
    check("post_rst_add_done", 32'(done),   32'd1);
    check("post_rst_add",      32'(result), 32'h0005);
    end_op();

    // xor
    start_op(3'b011, 8'hF0, 8'h0F);
    tick();
    check("xor_done",   32'(done),   32'd1);
    check("xor_result", 32'(result), 32'h00FF);
    end_op();

    // no_op
    start_op(3'b000, 8'h12, 8'h34);
    ndone = 0;
    repeat (4) begin
      tick();
      ndone += int'(done);
    end
    check("noop_nodone", 32'(ndone),  32'd0);
    check("noop_result", 32'(result), 32'h00FF);
    end_op();

`ifdef TINYALU_ERR_EN
    start_op(3'b110, 8'h03, 8'h04);
    tick();
    check("err_done",   32'(done),   32'd1);
    check("err_flag",   32'(err),    32'd1);
    check("err_result", 32'(result), 32'h00FF);
    end_op();
    check("err_hold", 32'(err), 32'd1);
    start_op(3'b010, 8'h0F, 8'h03);
    tick();
    check("and_done",   32'(done),   32'd1);
    check("and_err",    32'(err),    32'd0);
    check("and_result", 32'(result), 32'h0003);
    end_op();
`else
    start_op(3'b110, 8'h03, 8'h04);
    ndone = 0;
    repeat (4) begin
      tick();
      ndone += int'(done);
    end
    check("op110_nodone", 32'(ndone),  32'd0);
    check("op110_result", 32'(result), 32'h00FF);
    end_op();
    start_op(3'b010, 8'h0F, 8'h03);
    tick();
    check("and_done",   32'(done),   32'd1);
    check("and_result", 32'(result), 32'h0003);
    end_op();
`endif

    // rst_op clears result without done
    start_op(3'b111, 8'h55, 8'h66);
    ndone = 0;
    repeat (3) begin
      tick();
      ndone += int'(done);
    end
    check("rstop_nodone", 32'(ndone),  32'd0);
    check("rstop_result", 32'(result), 32'h0);
    end_op();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
